// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one DATA_BITS word per frame (start, data LSB first, optional parity, stop bits).
// Latency: line drops to the start bit on the handshake edge; frame lasts DIVIDER*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
// Backpressure: tx_ready is high in IDLE and in the last cycle of the last stop bit, so frames can stream with no gap.
module uart_tx_frame #(
  parameter int FCLK      = 50000000,
  parameter int BAUD      = 9600,
  parameter int DIVIDER   = FCLK / BAUD,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_Tx,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 Tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_W = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Reject unsupported configurations at elaboration time.
  generate
    if (DIVIDER < 2) begin : g_bad_divider
      $error("uart_tx_frame: DIVIDER must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_out_q, tx_out_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;

  logic                   accept;
  logic                   cnt_last;
  logic                   stop_last_d;
  logic                   par_calc;

  assign accept   = tx_valid & tx_ready_q;
  assign cnt_last = (cnt_q == CNT_LAST);
  // Odd parity makes the total count of ones odd, so it is the inverted XOR.
  assign par_calc = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

  // Next-state logic: bit timing, shifting and state sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (accept) begin
      // A handshake always starts a fresh frame, whether from IDLE or the final stop cycle.
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = '0;
      stop_d  = 1'b0;
      shift_d = tx_data;
      par_d   = par_calc;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
        end
        S_START: begin
          if (cnt_last) begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
        S_DATA: begin
          if (cnt_last) begin
            shift_d = shift_q >> 1;
            if (idx_q == IDX_LAST) begin
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
              stop_d  = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (cnt_last) begin
            state_d = S_STOP;
            stop_d  = 1'b0;
          end
        end
        S_STOP: begin
          if (cnt_last) begin
            if (STOP_BITS == 1 || stop_q) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    stop_last_d = (STOP_BITS == 1) ? 1'b1 : stop_d;
    tx_done_d   = (state_d == S_STOP) && stop_last_d && (cnt_d == CNT_LAST);
    tx_ready_d  = (state_d == S_IDLE) || tx_done_d;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = par_d;
      default:  tx_out_d = 1'b1;
    endcase
  end

  // State and registered outputs; reset abandons any frame and forces the line idle.
  always_ff @(posedge clk_Tx or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign Tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three configurations (8N1/4, 7E2/4, 8O1/2) sharing clock and reset.
// Frame vectors store the expected line bits in time order (bit 0 = start bit).
// Hand sequences cover streaming, mid-frame reset and mid-frame input changes.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] txo;
  logic [2:0] bsy;
  logic [2:0] dne;
  logic [7:0] dat0;
  logic [6:0] dat1;
  logic [7:0] dat2;

  uart_tx_frame #(.DIVIDER(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk_Tx(clk), .reset(rst), .tx_data(dat0), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .Tx_out(txo[0]), .busy(bsy[0]), .tx_done(dne[0]));

  uart_tx_frame #(.DIVIDER(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk_Tx(clk), .reset(rst), .tx_data(dat1), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .Tx_out(txo[1]), .busy(bsy[1]), .tx_done(dne[1]));

  uart_tx_frame #(.DIVIDER(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk_Tx(clk), .reset(rst), .tx_data(dat2), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .Tx_out(txo[2]), .busy(bsy[2]), .tx_done(dne[2]));

  typedef struct {
    int          cfg;
    logic [8:0]  word;
    logic [11:0] frame;
    int          len;
    int          div;
  } vec_t;

  vec_t tbl [10];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input int cfg, input logic [8:0] w);
    case (cfg)
      0: dat0 = w[7:0];
      1: dat1 = w[6:0];
      default: dat2 = w[7:0];
    endcase
  endtask

  task automatic wait_ready(input int cfg, output bit ok);
    int t = 0;
    while (rdy[cfg] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (rdy[cfg] === 1'b1);
    if (!ok) chk("ready_timeout", 32'(rdy[cfg]), 32'd1);
  endtask

  // Hands one word over, then checks every cycle of the frame and the idle cycle after it.
  // glitch_j >= 0 pulses tx_valid with different data mid-frame.
  task automatic send_frame(input int cfg, input logic [8:0] word, input logic [11:0] exp,
                            input int len, input int div, input int glitch_j);
    bit ok;
    int last;
    wait_ready(cfg, ok);
    if (!ok) return;
    set_data(cfg, word);
    vld[cfg] = 1'b1;
    @(posedge clk);
    #1;
    vld[cfg] = 1'b0;
    chk("line_on_handshake", 32'(txo[cfg]), 32'd0);
    set_data(cfg, ~word);
    last = len * div - 1;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      chk("line_bit", 32'(txo[cfg]), 32'(exp[j / div]));
      chk("busy_in_frame", 32'(bsy[cfg]), 32'd1);
      chk("done_pulse", 32'(dne[cfg]), (j == last) ? 32'd1 : 32'd0);
      chk("ready_in_frame", 32'(rdy[cfg]), (j == last) ? 32'd1 : 32'd0);
      if (j == glitch_j) begin
        set_data(cfg, 9'h0AA);
        vld[cfg] = 1'b1;
      end
      if (j == glitch_j + 1) vld[cfg] = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", 32'(bsy[cfg]), 32'd0);
    chk("idle_line", 32'(txo[cfg]), 32'd1);
    chk("idle_ready", 32'(rdy[cfg]), 32'd1);
    chk("idle_done", 32'(dne[cfg]), 32'd0);
  endtask

  initial begin
    bit ok;
    int done_cnt;
    logic [11:0] e1, e2;

    // Expected frames, MSB-first literal: {stop(s), parity, data MSB..LSB, start}.
    tbl[0] = '{0, 9'h0A5, 12'b00_1_10100101_0, 10, 4};
    tbl[1] = '{0, 9'h001, 12'b00_1_00000001_0, 10, 4};
    tbl[2] = '{0, 9'h080, 12'b00_1_10000000_0, 10, 4};
    tbl[3] = '{0, 9'h03C, 12'b00_1_00111100_0, 10, 4};
    tbl[4] = '{1, 9'h053, 12'b0_11_0_1010011_0, 11, 4};
    tbl[5] = '{1, 9'h07F, 12'b0_11_1_1111111_0, 11, 4};
    tbl[6] = '{1, 9'h000, 12'b0_11_0_0000000_0, 11, 4};
    tbl[7] = '{2, 9'h000, 12'b0_1_1_00000000_0, 11, 2};
    tbl[8] = '{2, 9'h001, 12'b0_1_0_00000001_0, 11, 2};
    tbl[9] = '{2, 9'h0FF, 12'b0_1_1_11111111_0, 11, 2};

    rst  = 1'b1;
    vld  = 3'b000;
    dat0 = '0;
    dat1 = '0;
    dat2 = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("rst_line", 32'(txo[c]), 32'd1);
      chk("rst_ready", 32'(rdy[c]), 32'd0);
      chk("rst_busy", 32'(bsy[c]), 32'd0);
      chk("rst_done", 32'(dne[c]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) chk("ready_after_release", 32'(rdy[c]), 32'd1);

    // Table-driven frames.
    for (int i = 0; i < 10; i++)
      send_frame(tbl[i].cfg, tbl[i].word, tbl[i].frame, tbl[i].len, tbl[i].div, -1);

    // Back-to-back streaming of 0x01 then 0x80 with tx_valid held.
    e1 = tbl[1].frame;
    e2 = tbl[2].frame;
    done_cnt = 0;
    wait_ready(0, ok);
    if (ok) begin
      dat0   = 8'h01;
      vld[0] = 1'b1;
      @(posedge clk);
      #1;
      dat0 = 8'h80;
      for (int j = 0; j < 80; j++) begin
        @(negedge clk);
        chk("stream_line", 32'(txo[0]), 32'((j < 40) ? e1[j / 4] : e2[(j - 40) / 4]));
        chk("stream_busy", 32'(bsy[0]), 32'd1);
        chk("stream_ready", 32'(rdy[0]), (j == 39 || j == 79) ? 32'd1 : 32'd0);
        if (dne[0] === 1'b1) done_cnt++;
        if (j == 40) vld[0] = 1'b0;
      end
      chk("stream_done_count", 32'(done_cnt), 32'd2);
      @(negedge clk);
      chk("stream_idle_after", 32'(bsy[0]), 32'd0);
    end

    // Input changes mid-frame must not disturb the latched word or start another frame.
    send_frame(1, 9'h053, tbl[4].frame, 11, 4, 10);
    repeat (20) begin
      @(negedge clk);
      chk("no_extra_frame_busy", 32'(bsy[1]), 32'd0);
      chk("no_extra_frame_line", 32'(txo[1]), 32'd1);
    end

    // Reset asserted during the 3rd data bit of a 0x00 frame.
    wait_ready(0, ok);
    if (ok) begin
      dat0   = 8'h00;
      vld[0] = 1'b1;
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      repeat (14) @(negedge clk);
      chk("abort_line_low_before", 32'(txo[0]), 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_line", 32'(txo[0]), 32'd1);
      chk("abort_ready", 32'(rdy[0]), 32'd0);
      chk("abort_done", 32'(dne[0]), 32'd0);
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("abort_done_held", 32'(dne[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready_before_edge", 32'(rdy[0]), 32'd0);
      @(negedge clk);
      chk("abort_ready_after_edge", 32'(rdy[0]), 32'd1);
      chk("abort_line_idle", 32'(txo[0]), 32'd1);
      send_frame(0, 9'h03C, tbl[3].frame, 10, 4, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
